// File: rtl/decoder_scan_nto2n.sv
// N-to-2^N one-hot decoder with direct (handshaked) and optional auto-scan modes.
// Scan mode and its dwell counter exist only when DECODER_SCAN_EN is defined.
module decoder_scan_nto2n #(
  parameter int unsigned N     = 2,
  parameter int unsigned DWELL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      sel_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [2**N-1:0]   y,
  output logic              y_valid,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int unsigned W = 2**N;

`ifdef DECODER_SCAN_EN
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
`else
  typedef enum logic {IDLE, DIRECT} state_t;
`endif

  state_t         state, state_nxt;
  logic [W-1:0]   y_nxt;
  logic           y_valid_nxt;
  logic [N-1:0]   idx_nxt;

`ifdef DECODER_SCAN_EN
  logic [15:0]    cnt, cnt_nxt;
  logic           wrap_nxt;
  localparam logic [15:0] RELOAD = 16'(DWELL - 1);
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  assign in_ready = (state == DIRECT) && en;

  always_comb begin
    state_nxt   = state;
    y_nxt       = y;
    y_valid_nxt = y_valid;
    idx_nxt     = idx;
`ifdef DECODER_SCAN_EN
    cnt_nxt     = cnt;
    wrap_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (en) begin
`ifdef DECODER_SCAN_EN
          if (mode) begin
            state_nxt   = SCAN;
            idx_nxt     = '0;
            y_nxt       = W'(1);
            y_valid_nxt = 1'b1;
            cnt_nxt     = RELOAD;
          end else begin
            state_nxt   = DIRECT;
          end
`else
          state_nxt = DIRECT;
`endif
        end
      end
      DIRECT: begin
        if (!en) begin
          state_nxt   = IDLE;
          y_nxt       = '0;
          y_valid_nxt = 1'b0;
          idx_nxt     = '0;
        end else if (in_valid) begin
          y_nxt       = W'(1) << sel_in;
          idx_nxt     = sel_in;
          y_valid_nxt = 1'b1;
        end
      end
`ifdef DECODER_SCAN_EN
      SCAN: begin
        if (!en) begin
          state_nxt   = IDLE;
          y_nxt       = '0;
          y_valid_nxt = 1'b0;
          idx_nxt     = '0;
          cnt_nxt     = '0;
        end else if (cnt == '0) begin
          // idx wraps naturally at N bits; flag the 2^N-1 -> 0 step
          cnt_nxt  = RELOAD;
          idx_nxt  = idx + N'(1);
          y_nxt    = W'(1) << idx_nxt;
          wrap_nxt = (idx == '1);
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
`endif
      default: begin
        state_nxt   = IDLE;
        y_nxt       = '0;
        y_valid_nxt = 1'b0;
        idx_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      y       <= '0;
      y_valid <= 1'b0;
      idx     <= '0;
    end else begin
      state   <= state_nxt;
      y       <= y_nxt;
      y_valid <= y_valid_nxt;
      idx     <= idx_nxt;
    end
  end

`ifdef DECODER_SCAN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      wrap <= wrap_nxt;
    end
  end
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Self-checking bench: instance a (N=2, DWELL=4) and instance b (N=3, DWELL=1)
// checked against an arithmetic model of direct decode and timed scanning.
module tb_decoder_scan_nto2n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_en, a_mode, a_valid, a_ready, a_yv, a_wrap;
  logic [1:0] a_sel, a_idx;
  logic [3:0] a_y;
  logic       b_en, b_mode, b_valid, b_ready, b_yv, b_wrap;
  logic [2:0] b_sel, b_idx;
  logic [7:0] b_y;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  decoder_scan_nto2n #(.N(2), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .mode(a_mode), .sel_in(a_sel),
    .in_valid(a_valid), .in_ready(a_ready), .y(a_y), .y_valid(a_yv),
    .idx(a_idx), .wrap(a_wrap)
  );

  decoder_scan_nto2n #(.N(3), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .mode(b_mode), .sel_in(b_sel),
    .in_valid(b_valid), .in_ready(b_ready), .y(b_y), .y_valid(b_yv),
    .idx(b_idx), .wrap(b_wrap)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    a_en = 0; a_mode = 0; a_valid = 0; a_sel = '0;
    b_en = 0; b_mode = 0; b_valid = 0; b_sel = '0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (a_y !== 4'b0) begin n_fail++; $display("FAIL reset_y got %b want 0000", a_y); end
    n_checks++; if (a_yv !== 1'b0) begin n_fail++; $display("FAIL reset_yv got %b want 0", a_yv); end
    n_checks++; if (a_idx !== 2'b0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", a_idx); end
    n_checks++; if (a_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b want 0", a_wrap); end
    n_checks++; if (b_y !== 8'b0 || b_yv !== 1'b0) begin n_fail++; $display("FAIL reset_b got y=%b yv=%b want 0", b_y, b_yv); end
    a_en = 1'b1;
    tick;
    n_checks++; if (a_ready !== 1'b0 || a_yv !== 1'b0) begin n_fail++; $display("FAIL reset_hold got rdy=%b yv=%b want 0", a_ready, a_yv); end
    a_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick;
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready got %b want 0", a_ready); end
  endtask

  task automatic test_direct;
    a_en = 1'b1; a_mode = 1'b0;
    tick;
    n_checks++; if (a_ready !== 1'b1 || a_yv !== 1'b0) begin n_fail++; $display("FAIL direct_entry got rdy=%b yv=%b want 1 0", a_ready, a_yv); end
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s); a_valid = 1'b1;
      tick;
      n_checks++; if (a_y !== 4'(2**s)) begin n_fail++; $display("FAIL direct_y got %b want %b", a_y, 4'(2**s)); end
      n_checks++; if (a_idx !== 2'(s) || a_yv !== 1'b1) begin n_fail++; $display("FAIL direct_idx got %0d/%b want %0d/1", a_idx, a_yv, s); end
    end
    a_valid = 1'b0; a_sel = 2'd1;
    tick;
    n_checks++; if (a_y !== 4'b1000) begin n_fail++; $display("FAIL direct_hold got %b want 1000", a_y); end
  endtask

  task automatic test_direct_random;
    int unsigned exp_sel = 3;
    for (int i = 0; i < 40; i++) begin
      int unsigned v = $urandom_range(0, 1);
      int unsigned s = $urandom_range(0, 3);
      a_valid = v[0]; a_sel = 2'(s); a_mode = 1'($urandom_range(0, 1));
      tick;
      if (v != 0) exp_sel = s;
      n_checks++; if (a_y !== 4'(2**exp_sel) || a_idx !== 2'(exp_sel)) begin n_fail++; $display("FAIL rand_direct got y=%b idx=%0d want y=%b idx=%0d", a_y, a_idx, 4'(2**exp_sel), exp_sel); end
      n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rand_ready got %b want 1", a_ready); end
    end
    a_valid = 1'b0; a_mode = 1'b0; a_en = 1'b0;
    #1;
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL ready_comb got %b want 0", a_ready); end
    tick;
    n_checks++; if (a_y !== 4'b0 || a_yv !== 1'b0 || a_idx !== 2'b0) begin n_fail++; $display("FAIL direct_disable got y=%b yv=%b idx=%0d want 0", a_y, a_yv, a_idx); end
  endtask

`ifdef DECODER_SCAN_EN
  task automatic test_scan;
    int unsigned wraps = 0;
    a_mode = 1'b1; a_en = 1'b1;
    tick;
    for (int k = 0; k < 24; k++) begin
      int unsigned e = (k / 4) % 4;
      n_checks++; if (a_idx !== 2'(e) || a_y !== 4'(2**e) || a_yv !== 1'b1) begin n_fail++; $display("FAIL scan_k%0d got idx=%0d y=%b yv=%b want idx=%0d", k, a_idx, a_y, a_yv, e); end
      n_checks++; if (a_wrap !== (k > 0 && k % 16 == 0)) begin n_fail++; $display("FAIL scan_wrap_k%0d got %b", k, a_wrap); end
      n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL scan_ready got %b want 0", a_ready); end
      if (k < 20 && a_wrap === 1'b1) wraps++;
      a_valid = 1'($urandom_range(0, 1)); a_sel = 2'($urandom_range(0, 3)); a_mode = 1'($urandom_range(0, 1));
      tick;
    end
    n_checks++; if (wraps != 1) begin n_fail++; $display("FAIL scan_wrap_count got %0d want 1", wraps); end
    a_valid = 1'b0;
  endtask

  task automatic test_disable_mid_scan;
    a_en = 1'b0;
    tick;
    a_mode = 1'b1; a_en = 1'b1;
    tick;
    repeat (8) tick;
    n_checks++; if (a_idx !== 2'd2) begin n_fail++; $display("FAIL pre_disable_idx got %0d want 2", a_idx); end
    a_en = 1'b0;
    tick;
    n_checks++; if (a_y !== 4'b0 || a_yv !== 1'b0 || a_idx !== 2'b0 || a_ready !== 1'b0) begin n_fail++; $display("FAIL scan_disable got y=%b yv=%b idx=%0d rdy=%b want 0", a_y, a_yv, a_idx, a_ready); end
    a_en = 1'b1; a_mode = 1'b0;
    tick;
    n_checks++; if (a_ready !== 1'b1 || a_yv !== 1'b0) begin n_fail++; $display("FAIL reenable_direct got rdy=%b yv=%b want 1 0", a_ready, a_yv); end
  endtask

  task automatic test_scan_fast;
    b_en = 1'b1; b_mode = 1'b1;
    tick;
    for (int k = 0; k < 24; k++) begin
      n_checks++; if (b_idx !== 3'(k % 8) || b_y !== 8'(2**(k % 8))) begin n_fail++; $display("FAIL fast_k%0d got idx=%0d y=%b want idx=%0d", k, b_idx, b_y, k % 8); end
      n_checks++; if (b_wrap !== (k > 0 && k % 8 == 0)) begin n_fail++; $display("FAIL fast_wrap_k%0d got %b", k, b_wrap); end
      tick;
    end
    b_en = 1'b0;
    tick;
  endtask
`else
  task automatic test_no_scan;
    int unsigned exp_sel = 0;
    bit have = 0;
    b_en = 1'b1; b_mode = 1'b1;
    tick;
    n_checks++; if (b_ready !== 1'b1 || b_yv !== 1'b0) begin n_fail++; $display("FAIL noscan_entry got rdy=%b yv=%b want 1 0", b_ready, b_yv); end
    for (int i = 0; i < 16; i++) begin
      int unsigned v = $urandom_range(0, 1);
      int unsigned s = $urandom_range(0, 7);
      b_valid = v[0]; b_sel = 3'(s);
      tick;
      if (v != 0) begin exp_sel = s; have = 1; end
      n_checks++; if (b_wrap !== 1'b0) begin n_fail++; $display("FAIL noscan_wrap got %b want 0", b_wrap); end
      n_checks++; if (b_y !== (have ? 8'(2**exp_sel) : 8'b0) || b_yv !== have) begin n_fail++; $display("FAIL noscan_y got %b/%b want sel %0d valid %b", b_y, b_yv, exp_sel, have); end
    end
    b_valid = 1'b0; b_en = 1'b0;
    tick;
  endtask
`endif

  task automatic test_async_reset;
    a_en = 1'b0;
    tick;
    a_en = 1'b1; a_mode = 1'b0;
    tick;
    a_sel = 2'd2; a_valid = 1'b1;
    tick;
    n_checks++; if (a_y !== 4'b0100) begin n_fail++; $display("FAIL pre_reset_y got %b want 0100", a_y); end
    a_sel = 2'd3;
    a_mode = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (a_y !== 4'b0 || a_yv !== 1'b0 || a_idx !== 2'b0 || a_wrap !== 1'b0 || a_ready !== 1'b0) begin n_fail++; $display("FAIL async_reset got y=%b yv=%b idx=%0d w=%b rdy=%b want 0", a_y, a_yv, a_idx, a_wrap, a_ready); end
    a_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick;
`ifdef DECODER_SCAN_EN
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (a_idx !== 2'(k / 4) || a_y !== 4'(2**(k / 4))) begin n_fail++; $display("FAIL restart_k%0d got idx=%0d y=%b want idx=%0d", k, a_idx, a_y, k / 4); end
      tick;
    end
    a_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (a_y !== 4'b0 || a_yv !== 1'b0 || a_idx !== 2'b0) begin n_fail++; $display("FAIL mid_dwell_reset got y=%b yv=%b idx=%0d want 0", a_y, a_yv, a_idx); end
    @(negedge clk) rst_n = 1'b1;
    tick;
`else
    n_checks++; if (a_ready !== 1'b1 || a_wrap !== 1'b0 || a_yv !== 1'b0) begin n_fail++; $display("FAIL restart_direct got rdy=%b w=%b yv=%b want 1 0 0", a_ready, a_wrap, a_yv); end
    a_en = 1'b0;
    tick;
`endif
  endtask

  initial begin
    test_reset;
    test_direct;
    test_direct_random;
`ifdef DECODER_SCAN_EN
    test_scan;
    test_disable_mid_scan;
    test_scan_fast;
`else
    test_no_scan;
`endif
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
